// File: rtl/lbp_pkg.sv
// Shared constants and FSM state type for the LBP histogram block.
package lbp_pkg;

  localparam int unsigned NUM_BINS = 256;
  localparam int unsigned CNT_W    = 14;
  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned CODE_W   = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lbp_hist_if.sv
// Sample-in / histogram-out signal bundle for the LBP histogram block.
interface lbp_hist_if #(
  parameter int unsigned CNT_W = lbp_pkg::CNT_W
);

  logic                        lbp_valid;
  logic [lbp_pkg::ADDR_W-1:0]  lbp_addr;
  logic [lbp_pkg::CODE_W-1:0]  lbp_data;
  logic                        finish;
  logic                        hist_valid;
  logic [lbp_pkg::CODE_W-1:0]  hist_addr;
  logic [CNT_W-1:0]            hist_data;
  logic [lbp_pkg::ADDR_W-1:0]  sample_cnt;
  logic                        ovf;
  logic                        hist_done;

  // Upstream LBP stage / consumer side
  modport master (
    output lbp_valid, lbp_addr, lbp_data, finish,
    input  hist_valid, hist_addr, hist_data, sample_cnt, ovf, hist_done
  );

  // Histogram block side
  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, finish,
    output hist_valid, hist_addr, hist_data, sample_cnt, ovf, hist_done
  );

endinterface

// File: rtl/lbp_hist_bank.sv
// Register-array bin storage: one saturating increment port and one read port.
// The read port returns the post-increment value so a reader sees an increment
// landing on the same edge.
module lbp_hist_bank #(
  parameter int unsigned NUM_BINS = lbp_pkg::NUM_BINS,
  parameter int unsigned CNT_W    = lbp_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inc_en,
  input  logic [lbp_pkg::CODE_W-1:0] inc_code,
  output logic                       sat_hit_c,
  input  logic [lbp_pkg::CODE_W-1:0] rd_addr,
  output logic [CNT_W-1:0]           rd_data_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] bins_q [NUM_BINS];
  logic [CNT_W-1:0] bins_d [NUM_BINS];

  // Saturating increment of the addressed bin; flag attempts on a full bin
  always_comb begin
    bins_d    = bins_q;
    sat_hit_c = 1'b0;
    if (inc_en) begin
      if (bins_q[inc_code] == CNT_MAX) begin
        sat_hit_c = 1'b1;
      end else begin
        bins_d[inc_code] = bins_q[inc_code] + CNT_W'(1);
      end
    end
  end

  // Read with increment bypass
  always_comb begin
    rd_data_c = bins_d[rd_addr];
  end

  // Bin registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_BINS; i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      bins_q <= bins_d;
    end
  end

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates one bin per sample, then on finish streams
// all bins out once and parks in DONE until reset.
module lbp_hist #(
  parameter int unsigned NUM_BINS = lbp_pkg::NUM_BINS,
  parameter int unsigned CNT_W    = lbp_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lbp_valid,
  input  logic [lbp_pkg::ADDR_W-1:0] lbp_addr,
  input  logic [lbp_pkg::CODE_W-1:0] lbp_data,
  input  logic                       finish,
  output logic                       hist_valid,
  output logic [lbp_pkg::CODE_W-1:0] hist_addr,
  output logic [CNT_W-1:0]           hist_data,
  output logic [lbp_pkg::ADDR_W-1:0] sample_cnt,
  output logic                       ovf,
  output logic                       hist_done
);

  import lbp_pkg::state_e;
  import lbp_pkg::ACCUM;
  import lbp_pkg::FLUSH;
  import lbp_pkg::DUMP;
  import lbp_pkg::DONE;

  localparam int unsigned CODE_W = lbp_pkg::CODE_W;
  localparam int unsigned ADDR_W = lbp_pkg::ADDR_W;
  localparam logic [CODE_W-1:0] LAST_BIN = CODE_W'(NUM_BINS - 1);
  localparam logic [ADDR_W-1:0] CNT_SAT  = '1;

  state_e            state_q, state_d;
  logic              in_vld_q, in_vld_d;
  logic [CODE_W-1:0] in_code_q, in_code_d;
  logic [ADDR_W-1:0] sample_cnt_q, sample_cnt_d;
  logic              ovf_q, ovf_d;
  logic              hist_valid_q, hist_valid_d;
  logic [CODE_W-1:0] hist_addr_q, hist_addr_d;
  logic [CNT_W-1:0]  hist_data_q, hist_data_d;
  logic              hist_done_q, hist_done_d;

  logic              sat_hit_c;
  logic [CODE_W-1:0] rd_addr_c;
  logic [CNT_W-1:0]  rd_data_c;

  // The pixel address carries no information the histogram needs
  logic addr_unused;
  assign addr_unused = ^lbp_addr;

  lbp_hist_bank #(
    .NUM_BINS (NUM_BINS),
    .CNT_W    (CNT_W)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .inc_en    (in_vld_q),
    .inc_code  (in_code_q),
    .sat_hit_c (sat_hit_c),
    .rd_addr   (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  // Next-state, input capture, counters and dump sequencing
  always_comb begin
    state_d      = state_q;
    in_vld_d     = 1'b0;
    in_code_d    = in_code_q;
    sample_cnt_d = sample_cnt_q;
    ovf_d        = ovf_q | sat_hit_c;
    hist_valid_d = hist_valid_q;
    hist_addr_d  = hist_addr_q;
    hist_data_d  = hist_data_q;
    hist_done_d  = hist_done_q;
    rd_addr_c    = '0;

    if (lbp_valid && (state_q != ACCUM)) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      ACCUM: begin
        if (lbp_valid) begin
          in_vld_d  = 1'b1;
          in_code_d = lbp_data;
          if (sample_cnt_q != CNT_SAT) begin
            sample_cnt_d = sample_cnt_q + ADDR_W'(1);
          end
        end
        if (finish) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        rd_addr_c    = '0;
        hist_valid_d = 1'b1;
        hist_addr_d  = '0;
        hist_data_d  = rd_data_c;
        state_d      = DUMP;
      end
      DUMP: begin
        rd_addr_c = hist_addr_q + CODE_W'(1);
        if (hist_addr_q == LAST_BIN) begin
          hist_valid_d = 1'b0;
          hist_done_d  = 1'b1;
          state_d      = DONE;
        end else begin
          hist_addr_d = rd_addr_c;
          hist_data_d = rd_data_c;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ACCUM;
      in_vld_q     <= 1'b0;
      in_code_q    <= '0;
      sample_cnt_q <= '0;
      ovf_q        <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_addr_q  <= '0;
      hist_data_q  <= '0;
      hist_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_vld_q     <= in_vld_d;
      in_code_q    <= in_code_d;
      sample_cnt_q <= sample_cnt_d;
      ovf_q        <= ovf_d;
      hist_valid_q <= hist_valid_d;
      hist_addr_q  <= hist_addr_d;
      hist_data_q  <= hist_data_d;
      hist_done_q  <= hist_done_d;
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_addr  = hist_addr_q;
  assign hist_data  = hist_data_q;
  assign sample_cnt = sample_cnt_q;
  assign ovf        = ovf_q;
  assign hist_done  = hist_done_q;

endmodule
